ct_ebiu_cawt_table: RTL and testbench

CT_EBIU_CAWT_TABLE -- requirements
Module: ct_ebiu_cawt_table

---
 rtl/ct_ebiu_cawt_table_pkg.sv | 24 ++
 rtl/ct_ebiu_cawt_table_slot.sv | 86 ++++++++
 rtl/gated_clk_cell.sv | 28 ++
 rtl/ct_ebiu_cawt_table.sv | 125 ++++++++++++
 tb/tb_ct_ebiu_cawt_table.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_ebiu_cawt_table_pkg.sv
// Shared defaults, the entry-id width helper and the entry record for the
// non-cacheable write-address table (CAWT).
package ct_ebiu_cawt_table_pkg;

  localparam int CAWT_ADDRW   = 40;
  localparam int CAWT_IDX_LSB = 6;
  localparam int CAWT_MID_W   = 3;

  // Record fields are sized for the widest legal configuration; narrower
  // parameterisations zero-extend into them.
  localparam int CAWT_IDX_W_MAX = 32;
  localparam int CAWT_MID_W_MAX = 8;

  function automatic int cawt_id_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  typedef struct packed {
    logic                      vld;
    logic [CAWT_IDX_W_MAX-1:0] idx;
    logic [CAWT_MID_W_MAX-1:0] mid;
  } cawt_entry_t;

endpackage

// File: rtl/ct_ebiu_cawt_table_slot.sv
// One CAWT entry: valid bit on the free-running clock, index/master-ID on a
// per-entry gated clock, four index comparators and the PIU select decode.
module ct_ebiu_cawt_slot
  import ct_ebiu_cawt_table_pkg::*;
#(
  parameter int IDX_W   = 8,
  parameter int MID_W   = CAWT_MID_W,
  parameter int PIU_NUM = 4
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               ciu_icg_en,
  input  logic               pad_yy_icg_scan_en,
  input  logic               create_en,
  input  logic [IDX_W-1:0]   create_idx,
  input  logic [MID_W-1:0]   create_mid,
  input  logic               pop_en,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [IDX_W-1:0]   snp0_idx,
  input  logic [IDX_W-1:0]   snp1_idx,
  output logic               vld,
  output logic               rd_hit,
  output logic               wr_hit,
  output logic               snp0_hit,
  output logic               snp1_hit,
  output logic [PIU_NUM-1:0] piu_sel
);

  localparam int PIU_W = $clog2(PIU_NUM);

  logic             entry_clk;
  logic             vld_q;
  logic [IDX_W-1:0] idx_q;
  logic [MID_W-1:0] mid_q;
  cawt_entry_t      entry;
  logic             bcast;

  gated_clk_cell u_entry_icg (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (ciu_icg_en),
    .local_en           (create_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (entry_clk)
  );

  // Allocation only ever targets an invalid entry, so set and clear never
  // compete for the same slot.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst)         vld_q <= 1'b0;
    else if (create_en) vld_q <= 1'b1;
    else if (pop_en)    vld_q <= 1'b0;
  end

  // NOTE: the tag storage is a handful of flops, not a RAM, so it takes the
  // same asynchronous clear as the valid bit and is never seen as X.
  always_ff @(posedge entry_clk or posedge cpurst) begin
    if (cpurst) begin
      idx_q <= '0;
      mid_q <= '0;
    end else if (create_en) begin
      idx_q <= create_idx;
      mid_q <= create_mid;
    end
  end

  assign entry = '{vld: vld_q,
                   idx: CAWT_IDX_W_MAX'(idx_q),
                   mid: CAWT_MID_W_MAX'(mid_q)};

  assign vld      = entry.vld;
  assign rd_hit   = entry.vld & (entry.idx == CAWT_IDX_W_MAX'(rd_idx));
  assign wr_hit   = entry.vld & (entry.idx == CAWT_IDX_W_MAX'(wr_idx));
  assign snp0_hit = entry.vld & (entry.idx == CAWT_IDX_W_MAX'(snp0_idx));
  assign snp1_hit = entry.vld & (entry.idx == CAWT_IDX_W_MAX'(snp1_idx));

  // Bits above MID_W are zero, so the shifted OR is exactly the broadcast MSB.
  assign bcast   = |(entry.mid >> (MID_W - 1));
  assign piu_sel = {PIU_NUM{entry.vld}}
                 & ((PIU_NUM'(1) << entry.mid[PIU_W-1:0]) | {PIU_NUM{bcast}});

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: enable is captured while the clock is low so the
// gated clock never glitches.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en;
  logic clk_en_lat;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;
  assign clk_en          = clk_en_bf_latch | pad_yy_icg_scan_en;

  // NOTE: this is the one deliberate latch; it is transparent only while the
  // clock is low, which is what makes the AND gate below glitch-free.
  always_latch begin
    if (!clk_in) clk_en_lat <= clk_en;
  end

  assign clk_out = clk_in & clk_en_lat;

endmodule

// File: rtl/ct_ebiu_cawt_table.sv
// CAWT top: lowest-free allocator, occupancy counter and OR-reduction of the
// per-entry hit and PIU-select outputs.
module ct_ebiu_cawt_table
  import ct_ebiu_cawt_table_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 8,
  parameter int IDX_LSB = CAWT_IDX_LSB,
  parameter int ADDRW   = CAWT_ADDRW,
  parameter int MID_W   = CAWT_MID_W,
  parameter int PIU_NUM = 4
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst,
  input  logic                          ciu_icg_en,
  input  logic                          pad_yy_icg_scan_en,
  input  logic                          create_vld,
  input  logic [ADDRW-1:0]              create_addr,
  input  logic [MID_W-1:0]              create_mid,
  output logic                          create_rdy,
  output logic [cawt_id_w(ENTRIES)-1:0] create_id,
  input  logic                          pop_vld,
  input  logic [cawt_id_w(ENTRIES)-1:0] pop_id,
  input  logic [ADDRW-1:0]              rd_addr,
  input  logic [ADDRW-1:0]              wr_addr,
  input  logic [IDX_W-1:0]              snp0_index,
  input  logic [IDX_W-1:0]              snp1_index,
  output logic                          rd_hit,
  output logic                          wr_hit,
  output logic                          snp0_hit,
  output logic                          snp1_hit,
  output logic [ENTRIES-1:0]            vld_vec,
  output logic [PIU_NUM-1:0]            piu_pend,
  output logic [cawt_id_w(ENTRIES):0]   entry_cnt,
  output logic                          full,
  output logic                          empty
);

  localparam int ID_W  = cawt_id_w(ENTRIES);
  localparam int CNT_W = ID_W + 1;

  logic [IDX_W-1:0]   create_idx, rd_idx, wr_idx;
  logic               unused_addr_bits;
  logic [ENTRIES-1:0] create_sel, pop_sel;
  logic [ENTRIES-1:0] rd_hit_vec, wr_hit_vec, snp0_hit_vec, snp1_hit_vec;
  logic [PIU_NUM-1:0] piu_sel [ENTRIES];
  logic               create_fire, pop_fire, found;
  logic [CNT_W-1:0]   cnt_q;

  assign create_idx = create_addr[IDX_LSB +: IDX_W];
  assign rd_idx     = rd_addr[IDX_LSB +: IDX_W];
  assign wr_idx     = wr_addr[IDX_LSB +: IDX_W];

  // Line offset and tag bits above the index take no part in the compare.
  assign unused_addr_bits = ^{create_addr[ADDRW-1:IDX_LSB+IDX_W], create_addr[IDX_LSB-1:0],
                              rd_addr[ADDRW-1:IDX_LSB+IDX_W],     rd_addr[IDX_LSB-1:0],
                              wr_addr[ADDRW-1:IDX_LSB+IDX_W],     wr_addr[IDX_LSB-1:0]};

  assign full       = (cnt_q == CNT_W'(ENTRIES));
  assign empty      = (cnt_q == '0);
  assign create_rdy = ~full;
  assign entry_cnt  = cnt_q;

  // NOTE: every variable written here gets a default before the loop, so the
  // block stays purely combinational and infers no latch.
  always_comb begin
    create_id = '0;
    found     = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!vld_vec[i] && !found) begin
        create_id = ID_W'(i);
        found     = 1'b1;
      end
    end
  end

  assign create_fire = create_vld & create_rdy;
  assign pop_fire    = |(pop_sel & vld_vec);

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) cnt_q <= '0;
    else        cnt_q <= cnt_q + CNT_W'(create_fire) - CNT_W'(pop_fire);
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
    assign create_sel[i] = create_fire & (create_id == ID_W'(i));
    assign pop_sel[i]    = pop_vld & (pop_id == ID_W'(i));

    ct_ebiu_cawt_slot #(
      .IDX_W   (IDX_W),
      .MID_W   (MID_W),
      .PIU_NUM (PIU_NUM)
    ) u_slot (
      .forever_cpuclk     (forever_cpuclk),
      .cpurst             (cpurst),
      .ciu_icg_en         (ciu_icg_en),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .create_en          (create_sel[i]),
      .create_idx         (create_idx),
      .create_mid         (create_mid),
      .pop_en             (pop_sel[i]),
      .rd_idx             (rd_idx),
      .wr_idx             (wr_idx),
      .snp0_idx           (snp0_index),
      .snp1_idx           (snp1_index),
      .vld                (vld_vec[i]),
      .rd_hit             (rd_hit_vec[i]),
      .wr_hit             (wr_hit_vec[i]),
      .snp0_hit           (snp0_hit_vec[i]),
      .snp1_hit           (snp1_hit_vec[i]),
      .piu_sel            (piu_sel[i])
    );
  end

  assign rd_hit   = |rd_hit_vec;
  assign wr_hit   = |wr_hit_vec;
  assign snp0_hit = |snp0_hit_vec;
  assign snp1_hit = |snp1_hit_vec;

  always_comb begin
    piu_pend = '0;
    for (int i = 0; i < ENTRIES; i++) piu_pend = piu_pend | piu_sel[i];
  end

endmodule

// File: tb/tb_ct_ebiu_cawt_table.sv
// Directed bench for ct_ebiu_cawt_table: inputs change just after the falling
// edge and outputs are sampled 1ns later, well away from the rising edge.
module tb_ct_ebiu_cawt_table;

  logic        forever_cpuclk;
  logic        cpurst;
  logic        ciu_icg_en;
  logic        pad_yy_icg_scan_en;
  logic        create_vld;
  logic [39:0] create_addr;
  logic [2:0]  create_mid;
  logic        create_rdy;
  logic [2:0]  create_id;
  logic        pop_vld;
  logic [2:0]  pop_id;
  logic [39:0] rd_addr;
  logic [39:0] wr_addr;
  logic [7:0]  snp0_index;
  logic [7:0]  snp1_index;
  logic        rd_hit, wr_hit, snp0_hit, snp1_hit;
  logic [7:0]  vld_vec;
  logic [3:0]  piu_pend;
  logic [3:0]  entry_cnt;
  logic        full, empty;

  int checks   = 0;
  int failures = 0;

  ct_ebiu_cawt_table dut (
    .forever_cpuclk     (forever_cpuclk),
    .cpurst             (cpurst),
    .ciu_icg_en         (ciu_icg_en),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .create_vld         (create_vld),
    .create_addr        (create_addr),
    .create_mid         (create_mid),
    .create_rdy         (create_rdy),
    .create_id          (create_id),
    .pop_vld            (pop_vld),
    .pop_id             (pop_id),
    .rd_addr            (rd_addr),
    .wr_addr            (wr_addr),
    .snp0_index         (snp0_index),
    .snp1_index         (snp1_index),
    .rd_hit             (rd_hit),
    .wr_hit             (wr_hit),
    .snp0_hit           (snp0_hit),
    .snp1_hit           (snp1_hit),
    .vld_vec            (vld_vec),
    .piu_pend           (piu_pend),
    .entry_cnt          (entry_cnt),
    .full               (full),
    .empty              (empty)
  );

  initial begin
    forever_cpuclk = 1'b0;
    forever #5 forever_cpuclk = ~forever_cpuclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs that must hold whenever reset is asserted.
  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   create_rdy, 1);
    check({tag, "_id"},    create_id,  0);
    check({tag, "_hits"},  {rd_hit, wr_hit, snp0_hit, snp1_hit}, 0);
    check({tag, "_vld"},   vld_vec,    0);
    check({tag, "_piu"},   piu_pend,   0);
    check({tag, "_cnt"},   entry_cnt,  0);
    check({tag, "_full"},  full,       0);
    check({tag, "_empty"}, empty,      1);
  endtask

  initial begin
    cpurst = 1'b1;
    ciu_icg_en = 1'b0;
    pad_yy_icg_scan_en = 1'b0;
    create_vld = 1'b0;
    create_addr = '0;
    create_mid = '0;
    pop_vld = 1'b0;
    pop_id = '0;
    rd_addr = 40'h1000;
    wr_addr = '0;
    snp0_index = 8'h40;
    snp1_index = 8'h00;

    repeat (2) @(negedge forever_cpuclk);
    #1 check_reset_outputs("in_reset");

    // First create on the first edge after reset release; 0x1000 -> index 0x40.
    @(negedge forever_cpuclk);
    cpurst = 1'b0;
    create_vld = 1'b1; create_addr = 40'h1000; create_mid = 3'd1;
    #1 check("first_create_id", create_id, 0);
    check("creating_entry_no_hit", rd_hit, 0);
    check("first_create_rdy", create_rdy, 1);
    @(negedge forever_cpuclk);
    create_vld = 1'b0;
    #1 check("first_vld", vld_vec, 8'h01);
    check("first_piu", piu_pend, 4'b0010);
    check("first_cnt", entry_cnt, 1);
    check("first_rd_hit", rd_hit, 1);
    check("first_empty", empty, 0);

    // Fill entries 1..7 with index 0x80+k, master 0.
    for (int k = 1; k < 8; k++) begin
      create_vld = 1'b1;
      create_addr = 40'h2000 + 40'(k) * 40'h40;
      create_mid = 3'd0;
      #1 check($sformatf("fill_id_%0d", k), create_id, k);
      @(negedge forever_cpuclk);
    end
    create_vld = 1'b0;
    #1 check("full_flag", full, 1);
    check("full_rdy", create_rdy, 0);
    check("full_cnt", entry_cnt, 8);
    check("full_vld", vld_vec, 8'hFF);
    check("full_piu", piu_pend, 4'b0011);

    // Create while full is dropped; the simultaneous pop of 3 still lands.
    create_vld = 1'b1; create_addr = 40'h3000; create_mid = 3'd2;
    pop_vld = 1'b1; pop_id = 3'd3;
    #1 check("full_pop_rdy_low", create_rdy, 0);
    @(negedge forever_cpuclk);
    create_vld = 1'b0; pop_vld = 1'b0;
    wr_addr = 40'h3000; rd_addr = 40'h20C0;
    #1 check("after_pop3_cnt", entry_cnt, 7);
    check("after_pop3_vld", vld_vec, 8'hF7);
    check("after_pop3_full", full, 0);
    check("after_pop3_rdy", create_rdy, 1);
    check("after_pop3_next_id", create_id, 3);
    check("ignored_create_no_hit", wr_hit, 0);
    check("popped_entry_no_hit", rd_hit, 0);
    check("ignored_create_piu", piu_pend, 4'b0011);

    create_vld = 1'b1; create_addr = 40'h20C0; create_mid = 3'd0;
    #1 check("refill_id", create_id, 3);
    @(negedge forever_cpuclk);
    create_vld = 1'b0;
    #1 check("refill_vld", vld_vec, 8'hFF);
    check("refill_cnt", entry_cnt, 8);
    check("refill_rd_hit", rd_hit, 1);

    // Drain everything.
    pop_vld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pop_id = 3'(k);
      @(negedge forever_cpuclk);
    end
    pop_vld = 1'b0;
    #1 check("drain_empty", empty, 1);
    check("drain_cnt", entry_cnt, 0);
    check("drain_vld", vld_vec, 0);
    check("drain_piu", piu_pend, 0);
    check("drain_rd_hit", rd_hit, 0);

    // Broadcast master ID selects every PIU.
    create_vld = 1'b1; create_addr = 40'h1040; create_mid = 3'b100;
    #1 check("bcast_id", create_id, 0);
    @(negedge forever_cpuclk);
    create_vld = 1'b0;
    #1 check("bcast_piu", piu_pend, 4'b1111);
    pop_vld = 1'b1; pop_id = 3'd0;
    @(negedge forever_cpuclk);
    pop_vld = 1'b0;
    #1 check("bcast_pop_piu", piu_pend, 4'b0000);
    check("bcast_pop_empty", empty, 1);

    // 0x1040 and 0x5040 alias at index 0x41; 0x1000 (index 0x40) does not.
    create_vld = 1'b1; create_addr = 40'h1040; create_mid = 3'b100;
    @(negedge forever_cpuclk);
    create_addr = 40'h5040; create_mid = 3'd2;
    #1 check("alias_second_id", create_id, 1);
    @(negedge forever_cpuclk);
    create_vld = 1'b0;
    snp0_index = 8'h41; snp1_index = 8'h01;
    rd_addr = 40'h1000; wr_addr = 40'h5040;
    #1 check("alias_snp0_hit", snp0_hit, 1);
    check("alias_snp1_miss", snp1_hit, 0);
    check("alias_rd_miss", rd_hit, 0);
    check("alias_wr_hit", wr_hit, 1);
    check("alias_cnt", entry_cnt, 2);

    // Pop of an invalid entry changes nothing.
    pop_vld = 1'b1; pop_id = 3'd5;
    @(negedge forever_cpuclk);
    pop_vld = 1'b0;
    #1 check("bad_pop_cnt", entry_cnt, 2);
    check("bad_pop_vld", vld_vec, 8'h03);

    // Simultaneous create and pop both take effect.
    pop_vld = 1'b1; pop_id = 3'd0;
    create_vld = 1'b1; create_addr = 40'h1000; create_mid = 3'd1;
    #1 check("both_create_id", create_id, 2);
    @(negedge forever_cpuclk);
    pop_vld = 1'b0; create_vld = 1'b0;
    #1 check("both_vld", vld_vec, 8'h06);
    check("both_cnt", entry_cnt, 2);
    check("both_piu", piu_pend, 4'b0110);
    check("both_rd_hit", rd_hit, 1);
    check("both_snp0_hit", snp0_hit, 1);

    // Two more entries with the module clock-gate enable held on.
    ciu_icg_en = 1'b1;
    create_vld = 1'b1; create_addr = 40'h7000; create_mid = 3'd0;
    #1 check("icg_first_id", create_id, 0);
    @(negedge forever_cpuclk);
    create_addr = 40'h7040;
    #1 check("icg_second_id", create_id, 3);
    @(negedge forever_cpuclk);
    create_vld = 1'b0;
    #1 check("four_vld", vld_vec, 8'h0F);
    check("four_cnt", entry_cnt, 4);
    check("four_piu", piu_pend, 4'b0111);

    // Asynchronous reset between clock edges clears everything at once.
    #2 cpurst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge forever_cpuclk);
    cpurst = 1'b0;
    create_vld = 1'b1; create_addr = 40'h1000; create_mid = 3'd1;
    #1 check("post_reset_id", create_id, 0);
    @(negedge forever_cpuclk);
    create_vld = 1'b0;
    #1 check("post_reset_cnt", entry_cnt, 1);
    check("post_reset_vld", vld_vec, 8'h01);
    check("post_reset_rd_hit", rd_hit, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
